// File: rtl/rb_commit_unit_pkg.sv
// Shared parameters, FSM encoding and helpers for the reorder-buffer commit unit.
package rb_commit_unit_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned RB_SIZE   = 8;
    localparam int unsigned RB_INDEX  = 3;
    localparam int unsigned REG_INDEX = 5;
    localparam int unsigned COUNT_W   = RB_INDEX + 1;

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_STORE_WAIT = 1'b1
    } rb_state_t;

    // One-hot entry select used for the CDB clear pulse.
    function automatic logic [RB_SIZE-1:0] onehot(input logic [RB_INDEX-1:0] idx);
        return RB_SIZE'(1) << idx;
    endfunction

endpackage

// File: rtl/rb_entry_table.sv
// Per-entry busy/dest/is_store storage with one allocate and one clear port.
module rb_entry_table
    import rb_commit_unit_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_en,
    input  logic [RB_INDEX-1:0]               alloc_index,
    input  logic [REG_INDEX-1:0]              alloc_dest,
    input  logic                              alloc_is_store,
    input  logic                              clear_en,
    input  logic [RB_INDEX-1:0]               clear_index,
    output logic [RB_SIZE-1:0]                busy,
    output logic [RB_SIZE-1:0][REG_INDEX-1:0] dest,
    output logic [RB_SIZE-1:0]                is_store
);

    // Full blocks allocation, so alloc and clear never target the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            dest     <= '0;
            is_store <= '0;
        end else begin
            if (clear_en) begin
                busy[clear_index] <= 1'b0;
            end
            if (alloc_en) begin
                busy[alloc_index]     <= 1'b1;
                dest[alloc_index]     <= alloc_dest;
                is_store[alloc_index] <= alloc_is_store;
            end
        end
    end

endmodule

// File: rtl/rb_commit_unit.sv
// In-order retirement of reorder-buffer entries to the register file or memory.
module rb_commit_unit
    import rb_commit_unit_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_valid,
    input  logic [REG_INDEX-1:0]          alloc_dest,
    input  logic                          alloc_is_store,
    output logic                          alloc_ready,
    output logic [RB_INDEX-1:0]           alloc_index,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    input  logic [RB_SIZE-1:0]            CDB_data_valid,
    input  logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
    output logic [RB_SIZE-1:0]            rb_clear,
    output logic                          rf_we,
    output logic [REG_INDEX-1:0]          rf_waddr,
    output logic [WORD_SIZE-1:0]          rf_wdata,
    output logic                          mem_req,
    output logic [WORD_SIZE-1:0]          mem_addr,
    output logic [WORD_SIZE-1:0]          mem_wdata,
    input  logic                          mem_ack,
    output logic                          rb_empty
);

    rb_state_t                        state;
    logic [RB_INDEX-1:0]              head;
    logic [RB_INDEX-1:0]              tail;
    logic [COUNT_W-1:0]               count;
    logic [RB_SIZE-1:0]               busy;
    logic [RB_SIZE-1:0][REG_INDEX-1:0] dest;
    logic [RB_SIZE-1:0]               is_store;
    logic                             alloc_fire;
    logic                             head_ready;
    logic                             retire_fire;
    logic [WORD_SIZE-1:0]             head_data;
    logic [WORD_SIZE-1:0]             head_addr;

    assign alloc_ready = (count != COUNT_W'(RB_SIZE));
    assign rb_empty    = (count == '0);
    assign alloc_index = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign head_data   = CDB_data_data[int'(head) * WORD_SIZE +: WORD_SIZE];
    assign head_addr   = CDB_data_addr[int'(head) * WORD_SIZE +: WORD_SIZE];

    // A CDB valid only counts while the entry is still busy.
    always_comb begin
        head_ready  = busy[head] && CDB_data_valid[head];
        retire_fire = 1'b0;
        if (state == ST_IDLE) begin
            retire_fire = head_ready && !is_store[head];
        end else begin
            retire_fire = mem_ack;
        end
    end

    rb_entry_table u_entry_table (
        .clk            (clk),
        .reset          (reset),
        .alloc_en       (alloc_fire),
        .alloc_index    (tail),
        .alloc_dest     (alloc_dest),
        .alloc_is_store (alloc_is_store),
        .clear_en       (retire_fire),
        .clear_index    (head),
        .busy           (busy),
        .dest           (dest),
        .is_store       (is_store)
    );

    // Pointers, occupancy and the retire FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rb_clear  <= '0;
        end else begin
            rf_we    <= 1'b0;
            rb_clear <= '0;
            if (alloc_fire) begin
                tail <= tail + RB_INDEX'(1);
            end
            if (retire_fire) begin
                head <= head + RB_INDEX'(1);
            end
            if (alloc_fire && !retire_fire) begin
                count <= count + COUNT_W'(1);
            end else if (!alloc_fire && retire_fire) begin
                count <= count - COUNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (head_ready) begin
                        if (is_store[head]) begin
                            state     <= ST_STORE_WAIT;
                            mem_req   <= 1'b1;
                            mem_addr  <= head_addr;
                            mem_wdata <= head_data;
                        end else begin
                            rf_we    <= 1'b1;
                            rf_waddr <= dest[head];
                            rf_wdata <= head_data;
                            rb_clear <= onehot(head);
                        end
                    end
                end
                ST_STORE_WAIT: begin
                    if (mem_ack) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        rb_clear <= onehot(head);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rb_commit_unit.md
# rb_commit_unit

In-order retirement stage of the reorder buffer. The unit allocates entries to dispatch and tracks head, tail and occupancy. It reads the per-entry result data, valid and store-address vectors written by the CDB data controller, and retires the head entry into the register file (ALU/load results) or into memory (stores) via a request/acknowledge handshake. On every retirement it emits a one-hot clear so the CDB side drops the stale valid bit before the entry is reused.

## Interface
- WORD_SIZE, 32, data/address width
- RB_SIZE, 8, reorder-buffer entries (power of two)
- RB_INDEX, 3, log2(RB_SIZE)
- REG_INDEX, 5, register-file address width
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- alloc_valid  in  1  dispatch requests an entry
- alloc_dest  in  REG_INDEX  destination register of the new entry
- alloc_is_store  in  1  new entry is a store
- alloc_ready  out  1  an entry is free (combinational from count)
- alloc_index  out  RB_INDEX  index granted when alloc_valid && alloc_ready (equals tail)
- CDB_data_data  in  WORD_SIZE*RB_SIZE  entry i result at [i*WORD_SIZE +: WORD_SIZE]
- CDB_data_valid  in  RB_SIZE  entry i result present
- CDB_data_addr  in  RB_SIZE*WORD_SIZE  entry i store address
- rb_clear  out  RB_SIZE  one-hot, one cycle, entry retired
- rf_we, rf_waddr, rf_wdata  out  1/REG_INDEX/WORD_SIZE  register write
- mem_req, mem_addr, mem_wdata  out  1/WORD_SIZE/WORD_SIZE  store request
- mem_ack  in  1  store accepted
- rb_empty  out  1  count == 0

## Operation
- Per-entry state: busy, dest, is_store. head, tail: RB_INDEX bits, wrapping modulo RB_SIZE. count: RB_INDEX+1 bits, range 0..RB_SIZE.
- Allocation: on alloc_valid && alloc_ready, set busy[tail], dest and is_store, then tail+1. alloc_valid while full is ignored, with no state change.
- FSM states IDLE, STORE_WAIT.
- IDLE: retire condition is busy[head] && CDB_data_valid[head].
  - Non-store: at the next edge, rf_we=1, rf_waddr=dest[head], rf_wdata=data[head]; rb_clear[head]=1; busy[head]=0; head+1; count-1.
  - Store: go to STORE_WAIT with mem_req=1, mem_addr=addr[head], mem_wdata=data[head].
- STORE_WAIT: outputs held stable. On the edge sampling mem_ack=1: mem_req=0, rb_clear[head]=1, busy cleared, head+1, count-1, return to IDLE.
- Simultaneous allocate and retire in one cycle: count unchanged; both pointers advance.
- Allocation into the entry being retired in the same cycle is not possible, because full blocks allocation.
- CDB valid for an entry is honoured only while busy=1. The CDB side must deassert valid before the entry's next allocation completes; rb_clear provides this.
- Reset (including mid-STORE_WAIT) abandons any store. All outputs go to 0 and the store is not retried.

## Timing
- Reset values: head=tail=0, count=0, all busy=0, state IDLE, rf_we=0, mem_req=0, rb_clear=0, rf_waddr/rf_wdata/mem_addr/mem_wdata=0, alloc_ready=1, rb_empty=1, alloc_index=0.
- Register result: valid sampled at edge N; rf_we high during cycle N+1 only.
- Store: mem_req high from N+1 until the edge where mem_ack=1 is sampled. Minimum latency is 2 cycles from valid to free.
- Maximum throughput: one non-store retire per cycle.
- rf_we, mem_req and rb_clear are registered. alloc_ready and rb_empty are combinational from count.

## Structure
- WORD_SIZE, RB_SIZE, RB_INDEX, REG_INDEX and the FSM state encodings come from the shared parameters include.
- One sub-module, rb_entry_table: busy/dest/is_store storage with allocate and clear ports. The FSM and pointers stay in the top module.

## Test plan
- After reset, alloc 3 non-stores (dest 1, 2, 3). Assert CDB valid for entries 2, 0, 1 with data 0xA, 0xB, 0xC.
  - Required: rf writes in order r1=0xB, r2=0xC, r3=0xA, each after its head becomes valid.
  - rb_clear sequence: 001, 010, 100.
- Fill 8 entries: alloc_ready=0 and a 9th alloc_valid is ignored.
  - Retire one entry, then alloc in the same cycle as a second retire: count stays at 7.
  - tail wraps 7→0.
- Store at head with addr 0x100, data 0x55, and mem_ack delayed 3 cycles.
  - Required: mem_req held 3 cycles with stable address and data.
  - Retire on the ack edge; a following non-store retires the next cycle.
- Stale valid: CDB_data_valid[0]=1 while busy[0]=0. Required: no retire.
- Reset asserted during STORE_WAIT: next cycle mem_req=0, count=0, head=tail=0.
- Run 20 random allocate/complete cycles through 3 pointer wraps. Required: the retire order matches the allocation order.
